irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Memory-mapped interrupt controller between the SoC peripherals (systick, UART, GPIO) and the picoRV CPU interrupt input. It latches up to N interrupt sources into a pending register and applies a per-source enable mask and edge/level mode. It claims the lowest-numbered enabled pending source and holds a single CPU interrupt line until end-of-interrupt. It uses the same select/wstrb/addr/ready peripheral bus slave as the other SoC peripherals.

## Interface
- N, default 8: number of interrupt sources, legal range 1..16.
- clk  in  1: system clock; one clock, all logic on rising edge.
- reset_n  in  1: synchronous, active-low reset.
- select  in  1: bus select for this peripheral.
- wstrb  in  4: write strobes; 0 = read, any nonzero = full-word write.
- addr  in  4: byte offset; only 0x0, 0x4, 0x8, 0xC are decoded.
- data_i  in  32: write data.
- ready  out  1: bus acknowledge.
- data_o  out  32: registered read data.
- irq_src  in  N: interrupt requests, synchronous to clk, active high.
- irq_o  out  1: interrupt to CPU.
- eoi_i  in  1: end-of-interrupt pulse from the CPU.

## Operation
- Registers. Bits at index N and above read 0 and ignore writes.
  - 0x0 ENABLE (RW): per-source mask; reset 0.
  - 0x4 PENDING (R, W1C): latched requests; reset 0.
  - 0x8 MODE (RW): 1 = rising-edge, 0 = level; reset 0.
  - 0xC ACTIVE (R): bit31 = in service, bits[3:0] = claimed id, other bits 0. Any write to 0xC acts as EOI.
- Bus access:
  - Every cycle with select=1 produces ready=1 on the next cycle.
  - For a read, data_o is loaded on that same edge. An unmapped read loads 0. data_o holds its value otherwise.
  - Writes to 0x4 clear the PENDING bits set in data_i. Writes to unmapped offsets are ignored.
- Source capture. src_q is the registered copy of irq_src, reset 0.
  - Edge mode: pending[i] is set on the edge after a cycle with irq_src[i]=1 and src_q[i]=0.
  - Level mode: pending[i] is set on every edge where irq_src[i]=1.
  - Precedence for each bit: a set beats a W1C clear, and a set beats a claim clear in the same cycle.
- FSM, two states.
  - IDLE: irq_o=0. If (PENDING & ENABLE) != 0:
    - latch id = lowest set index;
    - clear pending[id] (claim);
    - irq_o <= 1; active_valid <= 1;
    - go to SERVICE.
  - SERVICE: irq_o=1. New requests keep accumulating in PENDING, and ENABLE changes take effect but do not preempt.
    - Exit on eoi_i=1 or a bus write to 0xC.
    - Exit actions: irq_o <= 0, active_valid <= 0, go to IDLE. The id field keeps its last value.
  - EOI in IDLE is ignored.
- A source disabled while pending stays pending. It is claimed when re-enabled.

## Timing
- Reset (reset_n=0 at an edge): ENABLE, PENDING, MODE, src_q = 0; FSM = IDLE; irq_o = 0; ready = 0; data_o = 0; ACTIVE = 0. Reset applied during SERVICE drops irq_o on that edge.
- Edge-mode latency: irq_src rises in cycle t; PENDING updates at edge t+1; irq_o = 1 after edge t+2.
- After EOI at edge e, irq_o = 0 for at least one cycle. The next claim occurs at edge e+1 at the earliest.
- ready is a one-cycle pulse per selected cycle. Back-to-back selects give back-to-back ready.
- Read of PENDING returns the value before that edge's updates. Read of ACTIVE in the claim cycle returns the pre-claim value.

## Test plan
- Reset and register access:
  - Stimulus: assert reset_n=0 for 2 cycles; write ENABLE=0xFFFFFFFF (N=8); read ENABLE.
  - Required response: all outputs 0 during reset; the read returns 0x000000FF; ready rises one cycle after select.
- Edge source:
  - Stimulus: MODE=0x01, ENABLE=0x01; irq_src[0] high for 5 cycles.
  - Required response: irq_o rises 2 edges after irq_src[0] goes high; ACTIVE reads 0x80000000; PENDING reads 0 (exactly one capture).
  - Then pulse eoi_i: irq_o falls and does not reassert.
- Priority, masking and in-service blocking:
  - Stimulus: ENABLE=0x06; pulse sources 1, 2 and 3 simultaneously in edge mode.
  - Required response: claim id 1; PENDING=0x0C.
  - After EOI: id 2 is claimed after one idle cycle; PENDING=0x08.
  - After a further EOI: irq_o stays 0 (source 3 is masked).
- Level source:
  - Stimulus: MODE=0, ENABLE=0x10, irq_src[4] held high.
  - Required response: claim id 4; PENDING[4] is set again the next cycle. A W1C of 0x10 while the source is still high leaves PENDING[4]=1.
  - Drop the source, then W1C 0x10: PENDING reads 0.
- Collisions:
  - Set vs claim: a new edge on source 0 in the exact claim cycle of id 0 leaves PENDING[0]=1.
  - EOI by bus: a bus write to 0xC in SERVICE drops irq_o the same as eoi_i.
  - Reset mid-service: reset_n=0 during SERVICE clears everything.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the picoRV SoC.
//
// Latches up to N interrupt sources into PENDING, masks them with ENABLE,
// and selects edge or level capture per source with MODE. The lowest-numbered
// enabled pending source is claimed, and one CPU interrupt line is held
// until end-of-interrupt.
//
// Register map (byte offsets):
//   0x0 ENABLE  RW   per-source mask
//   0x4 PENDING R/W1C latched requests
//   0x8 MODE    RW   1 = rising edge, 0 = level
//   0xC ACTIVE  R    bit31 = in service, bits[3:0] = claimed id; any write = EOI
//
// Ports:
//   clk      system clock (rising edge)
//   reset_n  synchronous active-low reset
//   select   bus select; wstrb = 0 means read, nonzero means full-word write
//   addr     byte offset
//   data_i   write data
//   ready    one-cycle acknowledge for each selected cycle
//   data_o   registered read data
//   irq_src  N interrupt requests, active high, synchronous to clk
//   irq_o    interrupt line to the CPU
//   eoi_i    end-of-interrupt pulse from the CPU
module irq_ctrl #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          select,
  input  logic [3:0]    wstrb,
  input  logic [3:0]    addr,
  input  logic [31:0]   data_i,
  output logic          ready,
  output logic [31:0]   data_o,
  input  logic [N-1:0]  irq_src,
  output logic          irq_o,
  input  logic          eoi_i
);

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_MODE    = 4'h8;
  localparam logic [3:0] ADDR_ACTIVE  = 4'hC;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [N-1:0]   enable_r;
  logic [N-1:0]   pending_r;
  logic [N-1:0]   mode_r;
  logic [N-1:0]   src_q;
  logic           active_valid;
  logic [3:0]     active_id;

  logic           wr;
  logic           rd;
  logic           eoi_ev;
  logic           claim;
  logic [3:0]     claim_id;
  logic [N-1:0]   req;
  logic [N-1:0]   set_vec;
  logic [N-1:0]   w1c_vec;
  logic [N-1:0]   claim_vec;
  logic [N-1:0]   pending_next;

  // Write-data bits above the implemented sources are deliberately ignored.
  logic           unused_data;
  assign unused_data = ^data_i[31:N];

  // Zero-extend an N-bit register field to a 32-bit bus word.
  function automatic logic [31:0] widen(input logic [N-1:0] v);
    logic [31:0] r;
    r        = 32'd0;
    r[N-1:0] = v;
    return r;
  endfunction

  // Bus transaction decode and end-of-interrupt sources.
  always_comb begin
    wr     = select && (wstrb != 4'd0);
    rd     = select && (wstrb == 4'd0);
    eoi_ev = eoi_i || (wr && (addr == ADDR_ACTIVE));
  end

  // Per-source capture: rising edge against src_q, or plain level.
  always_comb begin
    set_vec = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (mode_r[i]) begin
        set_vec[i] = irq_src[i] & ~src_q[i];
      end else begin
        set_vec[i] = irq_src[i];
      end
    end
  end

  // Lowest-index enabled pending source; scanning downward lets the lowest win.
  always_comb begin
    req      = pending_r & enable_r;
    claim_id = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        claim_id = 4'(i);
      end else begin
        claim_id = claim_id;
      end
    end
  end

  // FSM next-state: claim from IDLE, leave SERVICE only on EOI (no preemption).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req != {N{1'b0}}) begin
          state_next = SERVICE;
        end else begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (eoi_ev) begin
          state_next = IDLE;
        end else begin
          state_next = SERVICE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the claim strobe and the one-hot pending bit it consumes.
  always_comb begin
    claim     = 1'b0;
    claim_vec = {N{1'b0}};
    case (state)
      IDLE: begin
        if (req != {N{1'b0}}) begin
          claim = 1'b1;
        end else begin
          claim = 1'b0;
        end
      end
      SERVICE: claim = 1'b0;
      default: claim = 1'b0;
    endcase
    for (int i = 0; i < N; i++) begin
      claim_vec[i] = claim && (claim_id == 4'(i));
    end
  end

  // Pending update: W1C and claim clear, a same-cycle set always wins.
  always_comb begin
    if (wr && (addr == ADDR_PENDING)) begin
      w1c_vec = data_i[N-1:0];
    end else begin
      w1c_vec = {N{1'b0}};
    end
    pending_next = (pending_r & ~w1c_vec & ~claim_vec) | set_vec;
  end

  // FSM state register plus the registered interrupt line and ACTIVE fields.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      irq_o        <= 1'b0;
      active_valid <= 1'b0;
      active_id    <= 4'd0;
    end else begin
      state        <= state_next;
      irq_o        <= (state_next == SERVICE);
      active_valid <= (state_next == SERVICE);
      if (claim) begin
        active_id <= claim_id;
      end else begin
        active_id <= active_id;
      end
    end
  end

  // Control registers, pending latch and source history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_r  <= {N{1'b0}};
      mode_r    <= {N{1'b0}};
      pending_r <= {N{1'b0}};
      src_q     <= {N{1'b0}};
    end else begin
      if (wr && (addr == ADDR_ENABLE)) begin
        enable_r <= data_i[N-1:0];
      end
      if (wr && (addr == ADDR_MODE)) begin
        mode_r <= data_i[N-1:0];
      end
      pending_r <= pending_next;
      src_q     <= irq_src;
    end
  end

  // Bus response: ready for every selected cycle, read data captured pre-update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready  <= 1'b0;
      data_o <= 32'd0;
    end else begin
      ready <= select;
      if (rd) begin
        case (addr)
          ADDR_ENABLE:  data_o <= widen(enable_r);
          ADDR_PENDING: data_o <= widen(pending_r);
          ADDR_MODE:    data_o <= widen(mode_r);
          ADDR_ACTIVE:  data_o <= {active_valid, 27'd0, active_id};
          default:      data_o <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (N = 8). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        select;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic [7:0]  irq_src;
  logic        irq_o;
  logic        eoi_i;

  int          n_checks;
  int          n_fail;
  logic [31:0] rdata;

  irq_ctrl #(.N(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .select  (select),
    .wstrb   (wstrb),
    .addr    (addr),
    .data_i  (data_i),
    .ready   (ready),
    .data_o  (data_o),
    .irq_src (irq_src),
    .irq_o   (irq_o),
    .eoi_i   (eoi_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    select = 1'b1;
    wstrb  = 4'hF;
    addr   = a;
    data_i = d;
    tick();
    select = 1'b0;
    wstrb  = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    select = 1'b1;
    wstrb  = 4'h0;
    addr   = a;
    tick();
    d      = data_o;
    select = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    select  = 1'b1;
    wstrb   = 4'h0;
    addr    = 4'h0;
    tick();
    tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b want 0", irq_o); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", ready); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
    select  = 1'b0;
    reset_n = 1'b1;
    tick();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %0b want 0", ready); end
    select = 1'b1; wstrb = 4'hF; addr = 4'h0; data_i = 32'hFFFF_FFFF;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL write_ready: got %0b want 1", ready); end
    select = 1'b0; wstrb = 4'h0;
    tick();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_pulse: got %0b want 0", ready); end
    bus_read(4'h0, rdata);
    n_checks++; if (rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL enable_read: got %h want 000000ff", rdata); end
  endtask

  task automatic test_back_to_back();
    select = 1'b1; wstrb = 4'h0; addr = 4'h2;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %0b want 1", ready); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", data_o); end
    addr = 4'h0;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %0b want 1", ready); end
    n_checks++; if (data_o !== 32'h0000_00FF) begin n_fail++; $display("FAIL b2b_data: got %h want 000000ff", data_o); end
    select = 1'b0;
    tick();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_end: got %0b want 0", ready); end
    n_checks++; if (data_o !== 32'h0000_00FF) begin n_fail++; $display("FAIL data_hold: got %h want 000000ff", data_o); end
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_edge();
    bus_write(4'h8, 32'h01);
    bus_write(4'h0, 32'h01);
    irq_src = 8'h01;
    tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL edge_lat1: got %0b want 0", irq_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL edge_lat2: got %0b want 1", irq_o); end
    bus_read(4'hC, rdata);
    n_checks++; if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL edge_active: got %h want 80000000", rdata); end
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL edge_pending: got %h want 0", rdata); end
    tick();
    irq_src = 8'h00;
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL edge_eoi: got %0b want 0", irq_o); end
    repeat (3) tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL edge_no_reassert: got %0b want 0", irq_o); end
  endtask

  task automatic test_priority();
    bus_write(4'h8, 32'h0F);
    bus_write(4'h0, 32'h06);
    irq_src = 8'h0E;
    tick();
    irq_src = 8'h00;
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL prio_irq1: got %0b want 1", irq_o); end
    bus_read(4'hC, rdata);
    n_checks++; if (rdata !== 32'h8000_0001) begin n_fail++; $display("FAIL prio_id1: got %h want 80000001", rdata); end
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0000_000C) begin n_fail++; $display("FAIL prio_pend1: got %h want 0000000c", rdata); end
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %0b want 0", irq_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL prio_irq2: got %0b want 1", irq_o); end
    bus_read(4'hC, rdata);
    n_checks++; if (rdata !== 32'h8000_0002) begin n_fail++; $display("FAIL prio_id2: got %h want 80000002", rdata); end
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0000_0008) begin n_fail++; $display("FAIL prio_pend2: got %h want 00000008", rdata); end
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    repeat (3) tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL prio_masked: got %0b want 0", irq_o); end
    bus_write(4'h4, 32'hFF);
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL prio_w1c_all: got %h want 0", rdata); end
  endtask

  task automatic test_level();
    bus_write(4'h8, 32'h00);
    bus_write(4'h0, 32'h10);
    irq_src = 8'h10;
    tick();
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL level_irq: got %0b want 1", irq_o); end
    bus_read(4'hC, rdata);
    n_checks++; if (rdata !== 32'h8000_0004) begin n_fail++; $display("FAIL level_id: got %h want 80000004", rdata); end
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0000_0010) begin n_fail++; $display("FAIL level_reset_again: got %h want 00000010", rdata); end
    bus_write(4'h4, 32'h10);
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0000_0010) begin n_fail++; $display("FAIL level_set_beats_w1c: got %h want 00000010", rdata); end
    irq_src = 8'h00;
    bus_write(4'h4, 32'h10);
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL level_w1c: got %h want 0", rdata); end
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL level_done: got %0b want 0", irq_o); end
    bus_write(4'h0, 32'h0);
  endtask

  task automatic test_collisions();
    bus_write(4'h8, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL masked_hold: got %0b want 0", irq_o); end
    bus_write(4'h0, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL reenable_claim: got %0b want 1", irq_o); end
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0000_0001) begin n_fail++; $display("FAIL set_beats_claim: got %h want 00000001", rdata); end
    bus_read(4'hC, rdata);
    n_checks++; if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL coll_active: got %h want 80000000", rdata); end
    bus_write(4'hC, 32'h0);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL bus_eoi: got %0b want 0", irq_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL reclaim_after_bus_eoi: got %0b want 1", irq_o); end
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    reset_n = 1'b0;
    tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL midsvc_reset_irq: got %0b want 0", irq_o); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL midsvc_reset_data: got %h want 0", data_o); end
    reset_n = 1'b1;
    bus_read(4'h0, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midsvc_enable: got %h want 0", rdata); end
    bus_read(4'h4, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midsvc_pending: got %h want 0", rdata); end
    bus_read(4'h8, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midsvc_mode: got %h want 0", rdata); end
    bus_read(4'hC, rdata);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midsvc_active: got %h want 0", rdata); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL midsvc_irq_after: got %0b want 0", irq_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    select   = 1'b0;
    wstrb    = 4'h0;
    addr     = 4'h0;
    data_i   = 32'h0;
    irq_src  = 8'h00;
    eoi_i    = 1'b0;
    test_reset();
    test_back_to_back();
    test_edge();
    test_priority();
    test_level();
    test_collisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
